// File: rtl/iq_serializer.sv
`default_nettype none
// ============================================================================
//  Module   : iq_serializer
//  Purpose  : Packs N_CH parallel I/Q pairs into a strobed DW-bit word burst
//             (I0,Q0,I1,Q1,...), with one pending set of double-buffering.
//  Revision : 1.0  initial release
// ============================================================================
module iq_serializer #(
    parameter int DW   = 20,
    parameter int N_CH = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               strobe_in,
    input  logic [N_CH*DW-1:0] i_in,
    input  logic [N_CH*DW-1:0] q_in,
    input  logic               overrun_clr,
    output logic [DW-1:0]      stream_out,
    output logic               strobe_out,
    output logic               busy,
    output logic               overrun,
    output logic [15:0]        drop_cnt
);

    localparam int NW = 2 * N_CH;
    localparam int IW = (NW > 1) ? $clog2(NW) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NW - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    state_t               state_q;
    logic [IW-1:0]        idx_q;
    logic [N_CH*DW-1:0]   active_i_q;
    logic [N_CH*DW-1:0]   active_q_q;
    logic [N_CH*DW-1:0]   pend_i_q;
    logic [N_CH*DW-1:0]   pend_q_q;
    logic                 pend_valid_q;
    logic [DW-1:0]        stream_q;
    logic                 strobe_q;
    logic                 busy_q;
    logic                 overrun_q;
    logic [15:0]          drop_cnt_q;

    logic [IW-1:0]        idx_d;
    logic [DW-1:0]        next_word;
    int                   next_ch;

    assign idx_d = idx_q + IW'(1);

    // Output is registered, so the word shown next cycle is selected by idx+1.
    always_comb begin
        next_ch   = int'(idx_d >> 1);
        next_word = idx_d[0] ? active_q_q[next_ch*DW +: DW]
                             : active_i_q[next_ch*DW +: DW];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            idx_q        <= '0;
            pend_valid_q <= 1'b0;
            stream_q     <= '0;
            strobe_q     <= 1'b0;
            busy_q       <= 1'b0;
            overrun_q    <= 1'b0;
            drop_cnt_q   <= '0;
        end else begin
            strobe_q <= 1'b0;
            stream_q <= '0;
            // A drop later in this block overrides the clear.
            if (overrun_clr) begin
                overrun_q <= 1'b0;
            end

            case (state_q)
                S_IDLE: begin
                    busy_q <= strobe_in;
                    if (strobe_in) begin
                        active_i_q <= i_in;
                        active_q_q <= q_in;
                        idx_q      <= '0;
                        strobe_q   <= 1'b1;
                        stream_q   <= i_in[DW-1:0];
                        state_q    <= S_SEND;
                    end
                end

                S_SEND: begin
                    busy_q <= 1'b1;
                    if (idx_q == LAST_IDX) begin
                        state_q <= S_GAP;
                    end else begin
                        idx_q    <= idx_d;
                        strobe_q <= 1'b1;
                        stream_q <= next_word;
                    end
                    if (strobe_in) begin
                        if (!pend_valid_q) begin
                            pend_i_q     <= i_in;
                            pend_q_q     <= q_in;
                            pend_valid_q <= 1'b1;
                        end else begin
                            overrun_q <= 1'b1;
                            if (drop_cnt_q != 16'hFFFF) begin
                                drop_cnt_q <= drop_cnt_q + 16'd1;
                            end
                        end
                    end
                end

                S_GAP: begin
                    if (pend_valid_q) begin
                        active_i_q   <= pend_i_q;
                        active_q_q   <= pend_q_q;
                        pend_valid_q <= strobe_in;
                        if (strobe_in) begin
                            pend_i_q <= i_in;
                            pend_q_q <= q_in;
                        end
                        idx_q    <= '0;
                        strobe_q <= 1'b1;
                        stream_q <= pend_i_q[DW-1:0];
                        busy_q   <= 1'b1;
                        state_q  <= S_SEND;
                    end else if (strobe_in) begin
                        active_i_q <= i_in;
                        active_q_q <= q_in;
                        idx_q      <= '0;
                        strobe_q   <= 1'b1;
                        stream_q   <= i_in[DW-1:0];
                        busy_q     <= 1'b1;
                        state_q    <= S_SEND;
                    end else begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end

                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign stream_out = stream_q;
    assign strobe_out = strobe_q;
    assign busy       = busy_q;
    assign overrun    = overrun_q;
    assign drop_cnt   = drop_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_iq_serializer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_iq_serializer
//  Purpose  : Scoreboard bench for iq_serializer with a burst-schedule model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_iq_serializer;

    localparam int DW   = 20;
    localparam int N_CH = 4;
    localparam int NW   = 2 * N_CH;

    logic               clk = 1'b0;
    logic               reset;
    logic               strobe_in;
    logic [N_CH*DW-1:0] i_in;
    logic [N_CH*DW-1:0] q_in;
    logic               overrun_clr;
    logic [DW-1:0]      stream_out;
    logic               strobe_out;
    logic               busy;
    logic               overrun;
    logic [15:0]        drop_cnt;

    iq_serializer #(.DW(DW), .N_CH(N_CH)) dut (
        .clk         (clk),
        .reset       (reset),
        .strobe_in   (strobe_in),
        .i_in        (i_in),
        .q_in        (q_in),
        .overrun_clr (overrun_clr),
        .stream_out  (stream_out),
        .strobe_out  (strobe_out),
        .busy        (busy),
        .overrun     (overrun),
        .drop_cnt    (drop_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d actual=%0h required=%0h", name, cyc, act, exp);
        end
    endtask

    // Model: each accepted set becomes a burst [start, start+NW-1] plus gap.
    typedef struct { int c; logic [DW-1:0] w; } exp_t;
    typedef struct { int st; logic [N_CH*DW-1:0] iv; logic [N_CH*DW-1:0] qv; } frm_t;

    exp_t wq[$];
    frm_t fq[$];
    int   bst[$];
    int   ben[$];
    bit   m_ov     = 1'b0;
    int   m_drop   = 0;
    bit   ov_cur   = 1'b0;
    int   drop_cur = 0;
    int   accepted = 0;
    bit   mon_en   = 1'b0;

    always @(posedge clk) begin
        ov_cur   <= m_ov;
        drop_cur <= m_drop;
    end

    function automatic bit busy_exp(input int c);
        for (int j = bst.size() - 1; j >= 0 && j >= bst.size() - 4; j--)
            if (bst[j] <= c && c <= ben[j]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [N_CH*DW-1:0] rand_vec();
        logic [N_CH*DW-1:0] v;
        for (int k = 0; k < N_CH; k++) v[k*DW +: DW] = DW'($urandom);
        return v;
    endfunction

    task automatic step(input bit s, input bit c, input bit r,
                        input logic [N_CH*DW-1:0] iv, input logic [N_CH*DW-1:0] qv);
        int t;
        int st;
        bit drop;
        t    = cyc;
        drop = 1'b0;
        strobe_in   = s;
        overrun_clr = c;
        reset       = r;
        i_in        = iv;
        q_in        = qv;
        if (r) begin
            while (wq.size() > 0 && wq[wq.size()-1].c > t) void'(wq.pop_back());
            while (bst.size() > 0 && bst[bst.size()-1] > t) begin
                void'(bst.pop_back());
                void'(ben.pop_back());
            end
            if (ben.size() > 0 && ben[ben.size()-1] > t) ben[ben.size()-1] = t;
            while (fq.size() > 0 && fq[fq.size()-1].st + NW - 1 > t) void'(fq.pop_back());
            m_ov   = 1'b0;
            m_drop = 0;
        end else begin
            if (s) begin
                if (bst.size() > 0 && bst[bst.size()-1] > t + 1) begin
                    drop = 1'b1;
                    m_ov = 1'b1;
                    if (m_drop < 65535) m_drop++;
                end else begin
                    st = t + 1;
                    if (ben.size() > 0 && ben[ben.size()-1] + 1 > st) st = ben[ben.size()-1] + 1;
                    bst.push_back(st);
                    ben.push_back(st + NW);
                    for (int k = 0; k < N_CH; k++) begin
                        wq.push_back('{c: st + 2*k,     w: iv[k*DW +: DW]});
                        wq.push_back('{c: st + 2*k + 1, w: qv[k*DW +: DW]});
                    end
                    fq.push_back('{st: st, iv: iv, qv: qv});
                    accepted++;
                end
            end
            if (c && !drop) m_ov = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 1'b0, 1'b0, rand_vec(), rand_vec());
    endtask

    task automatic go(input bit c);
        step(1'b1, c, 1'b0, rand_vec(), rand_vec());
    endtask

    // Monitor: per-cycle scoreboard plus a frame-level deserializer.
    logic [DW-1:0] dbuf [NW];
    int nbuf = 0;

    always @(negedge clk) begin : monitor
        bit                 es;
        logic [DW-1:0]      ew;
        logic [N_CH*DW-1:0] gi;
        logic [N_CH*DW-1:0] gq;
        frm_t               f;
        if (mon_en) begin
            es = (wq.size() > 0) && (wq[0].c == cyc);
            ew = es ? wq[0].w : '0;
            if (es) void'(wq.pop_front());
            chk("strobe_out", 128'(strobe_out), 128'(es));
            chk("stream_out", 128'(stream_out), 128'(ew));
            chk("busy",       128'(busy),       128'(busy_exp(cyc)));
            chk("overrun",    128'(overrun),    128'(ov_cur));
            chk("drop_cnt",   128'(drop_cnt),   128'(drop_cur));
            if (strobe_out === 1'b1) begin
                dbuf[nbuf] = stream_out;
                nbuf++;
                if (nbuf == NW) begin
                    for (int k = 0; k < N_CH; k++) begin
                        gi[k*DW +: DW] = dbuf[2*k];
                        gq[k*DW +: DW] = dbuf[2*k+1];
                    end
                    if (fq.size() == 0) begin
                        chk("loopback_frame_expected", 128'(0), 128'(1));
                    end else begin
                        f = fq.pop_front();
                        chk("loopback_i", 128'(gi), 128'(f.iv));
                        chk("loopback_q", 128'(gq), 128'(f.qv));
                    end
                    nbuf = 0;
                end
            end
            if (reset === 1'b1) nbuf = 0;
        end
    end

    initial begin
        logic [N_CH*DW-1:0] di;
        logic [N_CH*DW-1:0] dq;
        int target;
        int guard;

        reset       = 1'b1;
        strobe_in   = 1'b0;
        overrun_clr = 1'b0;
        i_in        = '0;
        q_in        = '0;
        @(posedge clk);
        #1;
        mon_en = 1'b1;
        step(1'b0, 1'b0, 1'b1, '0, '0);
        step(1'b0, 1'b0, 1'b1, '0, '0);
        idle(3);

        // Single directed frame.
        for (int k = 0; k < N_CH; k++) begin
            di[k*DW +: DW] = DW'(32'h10 + k);
            dq[k*DW +: DW] = DW'(32'h20 + k);
        end
        step(1'b1, 1'b0, 1'b0, di, dq);
        idle(12);

        // Back-to-back: second set arrives while word 3 is on the bus.
        go(1'b0);
        idle(3);
        go(1'b0);
        idle(25);

        // Overrun: three sets one cycle apart, then clear.
        go(1'b0);
        go(1'b0);
        go(1'b0);
        chk("overrun_after_drop", 128'(overrun), 128'(1));
        chk("drop_cnt_after_drop", 128'(drop_cnt), 128'(1));
        step(1'b0, 1'b1, 1'b0, rand_vec(), rand_vec());
        chk("overrun_after_clr", 128'(overrun), 128'(0));
        chk("drop_cnt_after_clr", 128'(drop_cnt), 128'(1));
        idle(25);

        // Strobe in the GAP cycle while a set is pending.
        go(1'b0);
        go(1'b0);
        idle(NW - 1);
        go(1'b0);
        idle(35);

        // Clear coinciding with a drop: the set wins.
        go(1'b0);
        go(1'b0);
        go(1'b1);
        chk("overrun_set_beats_clr", 128'(overrun), 128'(1));
        chk("drop_cnt_second_drop", 128'(drop_cnt), 128'(2));
        idle(25);
        step(1'b0, 1'b1, 1'b0, rand_vec(), rand_vec());
        idle(2);

        // Reset during word 5 with a set pending.
        go(1'b0);
        go(1'b0);
        idle(4);
        step(1'b0, 1'b0, 1'b1, rand_vec(), rand_vec());
        chk("strobe_after_reset", 128'(strobe_out), 128'(0));
        chk("busy_after_reset", 128'(busy), 128'(0));
        chk("drop_cnt_after_reset", 128'(drop_cnt), 128'(0));
        idle(25);

        // Randomized traffic: 1000 accepted frames.
        target = accepted + 1000;
        guard  = 0;
        while (accepted < target && guard < 40000) begin
            step($urandom_range(0, 5) == 0, $urandom_range(0, 19) == 0, 1'b0,
                 rand_vec(), rand_vec());
            guard++;
        end
        chk("random_phase_within_budget", 128'(accepted >= target), 128'(1));
        idle(40);

        chk("words_outstanding", 128'(wq.size()), 128'(0));
        chk("frames_outstanding", 128'(fq.size()), 128'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
